// File: rtl/barker_spreader_pkg.sv
// Shared DSSS constants for the Barker spreader and the RX despreader.
// Holds the Barker pattern, chip and bit counts, and the 802.11b scrambler seed and taps.
package barker_spreader_pkg;

   localparam int               CHIPS       = 11;
   localparam int               BITS        = 16;
   localparam logic [CHIPS-1:0] BARKER_CODE = 11'b10110111000;
   localparam logic [3:0]       LAST_CHIP   = 4'(CHIPS - 1);
   localparam logic [3:0]       LAST_BIT    = 4'(BITS - 1);
   localparam logic signed [15:0] AMP_DEFAULT = 16'sh2000;

   // Scrambler polynomial z^-7 + z^-4 + 1.
   localparam logic [6:0]       SCR_SEED    = 7'b1101100;
   localparam int               SCR_TAP_A   = 3;
   localparam int               SCR_TAP_B   = 6;

   typedef enum logic {
      IDLE   = 1'b0,
      SPREAD = 1'b1
   } state_t;

endpackage

// File: rtl/barker_spreader_if.sv
// Word input and chip-sample output bundle of the Barker spreader.
// The master side is tx_buffer/tx_chain; the slave side is the spreader.
interface barker_spreader_if;

   logic [15:0]        data_in;
   logic               data_valid;
   logic               data_ready;
   logic signed [15:0] i_out;
   logic signed [15:0] q_out;
   logic               strobe_out;

   modport master (
      output data_in, data_valid,
      input  data_ready, i_out, q_out, strobe_out
   );

   modport slave (
      input  data_in, data_valid,
      output data_ready, i_out, q_out, strobe_out
   );

endinterface

// File: rtl/barker_spreader_scrambler.sv
// 802.11b self-synchronizing scrambler (dsss_scrambler); exists only when
// BARKER_SPREADER_SCRAMBLER_EN is defined.
`ifdef BARKER_SPREADER_SCRAMBLER_EN
module barker_spreader_scrambler
   import barker_spreader_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic seed_load,
   input  logic advance,
   input  logic din,
   output logic dout
);

   logic [6:0] r;

   assign dout = din ^ r[SCR_TAP_A] ^ r[SCR_TAP_B];

   always_ff @(posedge clock) begin
      if (reset || seed_load) begin
         r <= SCR_SEED;
      end else if (advance) begin
         r <= {r[5:0], dout};
      end
   end

endmodule
`endif

// File: rtl/barker_spreader.sv
// 802.11b 1 Mbps DBPSK Barker spreader: 16-bit words in, one I/Q chip per strobe out.
// Optional scrambler in front of the differential encoder: BARKER_SPREADER_SCRAMBLER_EN.
//
// state  | meaning
// IDLE   | no word in flight; loads hold into shift when hold is full
// SPREAD | emitting 11 chips per bit on each strobe_in, LSB first
module barker_spreader
   import barker_spreader_pkg::*;
#(
   parameter logic signed [15:0] AMP    = AMP_DEFAULT,
   parameter logic [CHIPS-1:0]   BARKER = BARKER_CODE
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic strobe_in,
   input  logic clear_status,
   output logic busy,
   output logic underrun,
   barker_spreader_if.slave bus
);

   state_t      state;
   logic [15:0] hold;
   logic [15:0] shift;
   logic        hold_full;
   logic        phase;
   logic [3:0]  chip_idx;
   logic [3:0]  bit_idx;
   logic        payload_bit;
   logic        phase_next;
   logic        chip;
   logic        wr;

   assign bus.data_ready = ~hold_full;
   assign bus.q_out      = '0;
   assign busy           = (state == SPREAD);
   assign wr             = bus.data_valid & ~hold_full;
   assign phase_next     = (chip_idx == 4'd0) ? (phase ^ payload_bit) : phase;
   assign chip           = BARKER[LAST_CHIP - chip_idx] ^ phase_next;

`ifdef BARKER_SPREADER_SCRAMBLER_EN
   logic scr_advance;
   assign scr_advance = (state == SPREAD) & strobe_in & enable & (chip_idx == 4'd0);

   barker_spreader_scrambler u_dsss_scrambler (
      .clock     (clock),
      .reset     (reset),
      .seed_load (~enable),
      .advance   (scr_advance),
      .din       (shift[0]),
      .dout      (payload_bit)
   );
`else
   assign payload_bit = shift[0];
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         hold       <= '0;
         hold_full  <= 1'b0;
         shift      <= '0;
         phase      <= 1'b0;
         chip_idx   <= '0;
         bit_idx    <= '0;
         underrun   <= 1'b0;
         bus.i_out  <= '0;
         bus.strobe_out <= 1'b0;
      end else begin
         bus.strobe_out <= 1'b0;
         if (clear_status) begin
            underrun <= 1'b0;
         end

         if (!enable) begin
            // Shift contents are dropped; a word waiting in hold survives.
            state     <= IDLE;
            shift     <= '0;
            phase     <= 1'b0;
            chip_idx  <= '0;
            bit_idx   <= '0;
            bus.i_out <= '0;
         end else begin
            case (state)
               IDLE: begin
                  bus.i_out <= '0;
                  if (hold_full) begin
                     shift     <= hold;
                     hold_full <= 1'b0;
                     chip_idx  <= '0;
                     bit_idx   <= '0;
                     state     <= SPREAD;
                  end
               end
               SPREAD: begin
                  if (strobe_in) begin
                     bus.strobe_out <= 1'b1;
                     phase          <= phase_next;
                     bus.i_out      <= chip ? AMP : -AMP;
                     if (chip_idx == LAST_CHIP) begin
                        chip_idx <= '0;
                        bit_idx  <= bit_idx + 4'd1;
                        shift    <= shift >> 1;
                        if (bit_idx == LAST_BIT) begin
                           // Seamless reload, otherwise the last chip is shown once and IDLE zeroes i_out.
                           if (hold_full) begin
                              shift     <= hold;
                              hold_full <= 1'b0;
                           end else begin
                              underrun <= 1'b1;
                              state    <= IDLE;
                           end
                        end
                     end else begin
                        chip_idx <= chip_idx + 4'd1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end

         // A write can only happen while hold is empty, so it never races a drain.
         if (wr) begin
            hold      <= bus.data_in;
            hold_full <= 1'b1;
         end
      end
   end

endmodule
